// File: rtl/mux_rr_arbiter_if.sv
// Bus bundle for mux_rr_arbiter: request lines, the two data inputs, and the
// grant/select/data/valid outputs.
interface mux_rr_arbiter_if #(
  parameter int unsigned DATA_W = 8
);
  logic [1:0]        req;
  logic [DATA_W-1:0] x;
  logic [DATA_W-1:0] y;
  logic [1:0]        grant;
  logic              s;
  logic [DATA_W-1:0] m;
  logic              valid;

  modport master (output req, x, y, input grant, s, m, valid);
  modport slave  (input req, x, y, output grant, s, m, valid);
endinterface

// File: rtl/mux_rr_arbiter.sv
// Two-channel round-robin arbiter driving a registered 2:1 mux.
// Define MUX_ARB_TIMEOUT_EN to enable the hold counter and forced handover.
module mux_rr_arbiter #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned MAX_HOLD = 15,
  parameter int unsigned HOLD_W   = 8
) (
  input  logic                clock,
  input  logic                resetn,
  mux_rr_arbiter_if.slave     bus
);

  if ((MAX_HOLD < 1) || (MAX_HOLD > 255) || ((2 ** HOLD_W) <= MAX_HOLD)) begin : g_bad_cfg
    $error("mux_rr_arbiter: illegal MAX_HOLD/HOLD_W combination");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic              last_q, last_d;
  logic [DATA_W-1:0] m_q;
  logic              valid_q;
  logic              timeout;

`ifdef MUX_ARB_TIMEOUT_EN
  localparam logic [HOLD_W-1:0] HoldLast = HOLD_W'(MAX_HOLD - 1);
  logic [HOLD_W-1:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
`ifdef MUX_ARB_TIMEOUT_EN
    timeout = (cnt_q == HoldLast);
`else
    timeout = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        unique case (bus.req)
          2'b01:   state_d = GRANT0;
          2'b10:   state_d = GRANT1;
          2'b11:   state_d = last_q ? GRANT0 : GRANT1;
          default: state_d = IDLE;
        endcase
      end
      GRANT0: begin
        if (bus.req[0] && !(timeout && bus.req[1])) state_d = GRANT0;
        else if (bus.req[1])                        state_d = GRANT1;
        else                                        state_d = IDLE;
      end
      GRANT1: begin
        if (bus.req[1] && !(timeout && bus.req[0])) state_d = GRANT1;
        else if (bus.req[0])                        state_d = GRANT0;
        else                                        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if ((state_d == GRANT0) && (state_q != GRANT0)) last_d = 1'b0;
    if ((state_d == GRANT1) && (state_q != GRANT1)) last_d = 1'b1;

    grant_d = {state_d == GRANT1, state_d == GRANT0};

`ifdef MUX_ARB_TIMEOUT_EN
    // Counter restarts on any entry (including a channel switch) and saturates.
    if ((state_d == IDLE) || (state_d != state_q)) cnt_d = '0;
    else if (cnt_q != HoldLast)                    cnt_d = cnt_q + 1'b1;
    else                                           cnt_d = cnt_q;
`endif
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= 1'b1;
      m_q     <= '0;
      valid_q <= 1'b0;
`ifdef MUX_ARB_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      // Data follows the grant already registered, so m lags grant by one edge.
      if (grant_q != 2'b00) m_q <= grant_q[1] ? bus.y : bus.x;
      valid_q <= |grant_q;
`ifdef MUX_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign bus.grant = grant_q;
  assign bus.s     = grant_q[1];
  assign bus.m     = m_q;
  assign bus.valid = valid_q;

endmodule

// File: doc/mux_rr_arbiter.md
# mux_rr_arbiter

Round-robin arbiter and sequencer for a shared 2-to-1 data multiplexer. Two requesters (channel 0 on `x`, channel 1 on `y`) compete for one output channel. The block runs a 3-state FSM, drives the mux select `s`, and registers the selected data onto `m` with a `valid` qualifier. An optional hold timeout stops one requester from starving the other.

## Interface
- `DATA_W`, default 8: width of `x`, `y` and `m`.
- `MAX_HOLD`, default 15: maximum consecutive granted cycles before a forced handover. Legal range 1..255.
- `HOLD_W`, default 8: hold counter width; must satisfy 2^HOLD_W > MAX_HOLD.
- `clock`  in  1  single clock; all state updates on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `req`  in  2  request lines: `req[0]` for channel 0, `req[1]` for channel 1.
- `x`  in  DATA_W  channel 0 data (mux select 0).
- `y`  in  DATA_W  channel 1 data (mux select 1).
- `grant`  out  2  one-hot-or-zero grant, registered.
- `s`  out  1  mux select; equals `grant[1]`.
- `m`  out  DATA_W  registered mux output.
- `valid`  out  1  `m` holds granted data.

## Operation
- Reset values: FSM IDLE, `grant`=00, `s`=0, `m`=0, `valid`=0, hold counter 0, `last`=1. With `last`=1, channel 0 wins the first tie.
- States:
  - IDLE: `grant`=00.
  - GRANT0: `grant`=01.
  - GRANT1: `grant`=10.
- IDLE transitions:
  - `req`=00: stay in IDLE.
  - `req`=01: go to GRANT0.
  - `req`=10: go to GRANT1.
  - `req`=11: go to the channel ≠ `last`.
- GRANTk transitions (k = current owner, j = other channel):
  - `req[k]`=1, and either no timeout or `req[j]`=0: stay in GRANTk.
  - `req[k]`=0 and `req[j]`=1: go directly to GRANTj, with no IDLE bubble.
  - `req[k]`=0 and `req[j]`=0: go to IDLE.
  - Timeout (counter == MAX_HOLD−1) and `req[j]`=1: go to GRANTj, even though `req[k]`=1.
- Arbitration memory: `last` updates to k on every entry into GRANTk.
- Hold counter:
  - Clears to 0 on every entry into a GRANT state, including a switch between channels.
  - Increments each cycle the FSM stays in the same GRANT state.
  - Saturates at MAX_HOLD−1, which also means no wrap.
  - Held at 0 in IDLE.
- Datapath, evaluated every edge: `m` <= `grant[1]` ? `y` : `x` when `grant`≠00; otherwise `m` holds its value. `valid` <= |`grant`.
- `req` is level-sensitive. A requester may drop `req` in any cycle; it loses the grant on the next edge.
- Reset asserted mid-grant: all outputs clear immediately (asynchronously). Operation resumes from IDLE with `last`=1.

## Timing
- Request to grant: `req` sampled at edge N gives `grant`/`s` valid after edge N (1 cycle).
- Grant to data: data on `x`/`y` during the first grant cycle appears on `m` with `valid`=1 after the next edge (2 cycles from the request).
- Release: `req[k]` falls before edge N, so `grant[k]`=0 after N and `valid` deasserts after N+1, unless channel j took over.
- Handover: back-to-back GRANT0→GRANT1 has zero idle cycles, and `valid` stays high across the switch.
- Timeout: with both channels requesting continuously, each grant lasts exactly MAX_HOLD cycles.

## Configuration
- Macro: `MUX_ARB_TIMEOUT_EN`.
- Defined: hold counter and forced handover are implemented as described above.
- Undefined:
  - The counter is not instantiated.
  - A grant is held until the owner drops `req`.
  - The timeout transition never fires; all other behaviour is identical.

## Test plan
- Reset/tie: `resetn` low, then high, with `req`=11 → `grant`=01 after 1 edge; `s`=0; `m`=`x` and `valid`=1 one edge later.
- Single requester: `req`=10 with `y`=8'hA5 → `grant`=10 after 1 edge, `s`=1, `m`=8'hA5 after 2 edges. Drop `req` → `grant`=00 after 1 edge, `valid`=0 after 2 edges.
- Handover: GRANT0 held, then `req` goes 01→10 in one cycle → `grant` goes 01→10 on the next edge, `valid` never drops.
- Timeout (macro defined, MAX_HOLD=4): `req`=11 held for 16 cycles → `grant` pattern 01×4, 10×4, 01×4, 10×4. Without the macro → `grant` stays 01 for all 16 cycles.
- Async reset mid-grant: assert `resetn`=0 between edges while in GRANT1 → `grant`, `s`, `m`, `valid` read 0 before the next edge. Release with `req`=11 → `grant`=01.
- Round-robin: a single grant to channel 1, then IDLE, then `req`=11 → channel 0 granted.
